// File: rtl/ramfetcher_pkg.sv
// ramfetcher_pkg: shared definitions for the load-side RAM fetcher.
//   - size codes SZ_B/SZ_H/SZ_W/SZ_D (1/2/4/8 bytes)
//   - fetcher state encoding F_IDLE/F_ISSUE/F_DRAIN
//   - last_lane(): index of the final byte for a size code (byte count - 1)
package ramfetcher_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_ISSUE = 2'd1,
    F_DRAIN = 2'd2
  } fstate_e;

  function automatic logic [2:0] last_lane(input logic [1:0] size);
    logic [2:0] lane;
    case (size)
      SZ_B:    lane = 3'd0;
      SZ_H:    lane = 3'd1;
      SZ_W:    lane = 3'd3;
      default: lane = 3'd7;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/ramfetch_ext.sv
// ramfetch_ext: combinational sign/zero extension of an assembled load.
// Ports:
//   raw_i  [63:0] little-endian assembled bytes (lanes above the size are don't-care)
//   size_i [1:0]  size code, 1/2/4/8 bytes
//   sgn_i         1 = sign-extend, 0 = zero-extend (ignored for 8 bytes)
//   ext_o  [63:0] extended result
module ramfetch_ext
  import ramfetcher_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [63:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SZ_B:    ext_o = {{56{sgn_i & raw_i[7]}},  raw_i[7:0]};
      SZ_H:    ext_o = {{48{sgn_i & raw_i[15]}}, raw_i[15:0]};
      SZ_W:    ext_o = {{32{sgn_i & raw_i[31]}}, raw_i[31:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/ramfetcher.sv
// ramfetcher: reads 1/2/4/8 consecutive bytes from a byte-wide synchronous
// RAM, assembles them little-endian, extends to 64 bits and returns the
// result with a one-cycle done pulse. kp_o holds the pipeline while busy.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   start_i, size_i, sgn_i, add_i   load request (sampled only when idle)
//   ramq_i                  RAM read data, valid RAM_LAT edges after rd_o/adq_o
//   rd_o, adq_o             RAM read enable and byte address
//   kp_o, done_o, q_o       busy, result strobe, result
//
// state   | meaning
// F_IDLE  | waiting for start; rd_o=0, kp_o=0
// F_ISSUE | issuing one read per cycle, addresses add..add+N-1
// F_DRAIN | reads issued, waiting for the last byte to come back
module ramfetcher
  import ramfetcher_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [15:0] add_i,
  input  logic [7:0]  ramq_i,
  output logic        rd_o,
  output logic [15:0] adq_o,
  output logic        kp_o,
  output logic        done_o,
  output logic [63:0] q_o
);

  if (RAM_LAT != 1) begin : g_lat_chk
    $error("ramfetcher: only RAM_LAT=1 is supported");
  end

  fstate_e     state_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [2:0]  icnt_q;
  logic [2:0]  ccnt_q;
  logic        cap_v_q;
  logic [63:0] asm_q;
  logic [63:0] asm_d;
  logic [63:0] ext_val;
  logic        rd_q;
  logic [15:0] adq_q;
  logic        kp_q;
  logic        done_q;
  logic [63:0] q_q;

  // Current assembly with the byte arriving this cycle merged into its lane;
  // the final result is extended from this so no extra cycle is needed.
  always_comb begin
    asm_d = asm_q;
    asm_d[{ccnt_q, 3'b000} +: 8] = ramq_i;
  end

  ramfetch_ext u_ext (
    .raw_i  (asm_d),
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .ext_o  (ext_val)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= F_IDLE;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      icnt_q  <= 3'd0;
      ccnt_q  <= 3'd0;
      cap_v_q <= 1'b0;
      asm_q   <= 64'd0;
      rd_q    <= 1'b0;
      adq_q   <= 16'd0;
      kp_q    <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= 64'd0;
    end else begin
      done_q  <= 1'b0;
      // rd delayed by the RAM latency marks the cycle ramq_i holds valid data
      cap_v_q <= rd_q;
      if (cap_v_q) begin
        asm_q  <= asm_d;
        ccnt_q <= ccnt_q + 3'd1;
      end
      case (state_q)
        F_IDLE: begin
          if (start_i) begin
            size_q  <= size_i;
            sgn_q   <= sgn_i;
            adq_q   <= add_i;
            rd_q    <= 1'b1;
            kp_q    <= 1'b1;
            icnt_q  <= 3'd0;
            ccnt_q  <= 3'd0;
            asm_q   <= 64'd0;
            state_q <= F_ISSUE;
          end
        end
        F_ISSUE: begin
          if (icnt_q == last_lane(size_q)) begin
            rd_q    <= 1'b0;
            state_q <= F_DRAIN;
          end else begin
            adq_q  <= adq_q + 16'd1;
            icnt_q <= icnt_q + 3'd1;
          end
        end
        F_DRAIN: begin
          if (cap_v_q && (ccnt_q == last_lane(size_q))) begin
            q_q     <= ext_val;
            kp_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= F_IDLE;
          end
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end

  assign rd_o   = rd_q;
  assign adq_o  = adq_q;
  assign kp_o   = kp_q;
  assign done_o = done_q;
  assign q_o    = q_q;

endmodule

// File: tb/tb_ramfetcher.sv
module tb_ramfetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic        sgn;
  logic [15:0] add;
  logic [7:0]  ramq;
  logic        rd;
  logic [15:0] adq;
  logic        kp;
  logic        done;
  logic [63:0] q;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  // Byte-wide synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (rd) ramq <= mem[adq];
  end

  ramfetcher #(.RAM_LAT(1)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .size_i  (size),
    .sgn_i   (sgn),
    .add_i   (add),
    .ramq_i  (ramq),
    .rd_o    (rd),
    .adq_o   (adq),
    .kp_o    (kp),
    .done_o  (done),
    .q_o     (q)
  );

  // Reference: gather N bytes from the RAM image, then extend
  function automatic logic [63:0] model(input logic [15:0] a, input logic [1:0] sz, input logic s);
    logic [63:0] v;
    logic [63:0] ones;
    int n;
    n = 1 << sz;
    v = 64'd0;
    ones = '1;
    for (int i = 0; i < n; i++) v = v | (64'(mem[16'(a + 16'(i))]) << (8 * i));
    if (s && n < 8 && v[8 * n - 1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  // Issues one request from a negedge and follows it until done (or timeout).
  // lat counts rising edges from the accepting edge; -1 means no done seen.
  task automatic run_load(input logic [15:0] a, input logic [1:0] sz, input logic s,
                          output int lat, output logic [63:0] qv, output logic kp_at_done,
                          output int nrd, output logic addr_ok, output int kp_gaps);
    lat = -1; qv = '0; kp_at_done = 1'bx; nrd = 0; addr_ok = 1'b1; kp_gaps = 0;
    start = 1'b1; size = sz; sgn = s; add = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (rd) begin
        if (adq !== 16'(a + 16'(nrd))) addr_ok = 1'b0;
        nrd++;
      end
      if (done) begin
        lat = k;
        qv = q;
        kp_at_done = kp;
        break;
      end else if (!kp) begin
        kp_gaps++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; size = 2'b00; sgn = 1'b0; add = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd got %0b want 0", rd); end
    checks++; if (adq !== 16'h0) begin errors++; $display("FAIL reset_adq got %h want 0000", adq); end
    checks++; if (kp !== 1'b0) begin errors++; $display("FAIL reset_kp got %0b want 0", kp); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (q !== 64'd0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [15:0] a, input logic [1:0] sz,
                               input logic s, input logic [63:0] want_q);
    int lat, nrd, gaps; logic [63:0] qv; logic kpd, aok;
    run_load(a, sz, s, lat, qv, kpd, nrd, aok, gaps);
    checks++; if (qv !== want_q) begin errors++; $display("FAIL %s_q got %h want %h", name, qv, want_q); end
    checks++; if (lat !== (1 << sz) + 1) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, (1 << sz) + 1); end
    checks++; if (nrd !== (1 << sz) || !aok) begin errors++; $display("FAIL %s_rd got %0d cycles addr_ok=%0b want %0d cycles addr_ok=1", name, nrd, aok, 1 << sz); end
    checks++; if (kpd !== 1'b0 || gaps !== 0) begin errors++; $display("FAIL %s_kp got kp_at_done=%0b gaps=%0d want 0 0", name, kpd, gaps); end
  endtask

  task automatic test_random();
    int lat, nrd, gaps; logic [63:0] qv, want; logic kpd, aok;
    logic [15:0] a; logic [1:0] sz; logic s;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 3));
      s = 1'($urandom);
      a = (i % 4 == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 6))) : 16'($urandom);
      for (int j = 0; j < 8; j++) mem[16'(a + 16'(j))] = 8'($urandom);
      want = model(a, sz, s);
      run_load(a, sz, s, lat, qv, kpd, nrd, aok, gaps);
      checks++; if (qv !== want) begin errors++; $display("FAIL rand%0d_q got %h want %h", i, qv, want); end
      checks++; if (lat !== (1 << sz) + 1 || nrd !== (1 << sz) || !aok || gaps !== 0 || kpd !== 1'b0)
        begin errors++; $display("FAIL rand%0d_timing got lat=%0d nrd=%0d aok=%0b gaps=%0d kp=%0b want lat=%0d nrd=%0d 1 0 0",
                                 i, lat, nrd, aok, gaps, kpd, (1 << sz) + 1, 1 << sz); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want; logic exp_rd, exp_done;
    int dones = 0, rd_err = 0, done_err = 0, q_err = 0;
    logic [15:0] adq_second;
    adq_second = 16'hxxxx;
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33; mem[16'h0023] = 8'h44;
    want = 64'h0000_0000_4433_2211;
    start = 1'b1; size = 2'b10; sgn = 1'b0; add = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp_rd = (k <= 3) || (k >= 6 && k <= 9);
      exp_done = (k == 5) || (k == 11);
      if (rd !== exp_rd) rd_err++;
      if (done !== exp_done) done_err++;
      if (done) begin dones++; if (q !== want) q_err++; end
      if (k == 6) begin adq_second = adq; start = 1'b0; end
    end
    checks++; if (rd_err !== 0) begin errors++; $display("FAIL b2b_rd got %0d bad cycles want 0", rd_err); end
    checks++; if (done_err !== 0 || dones !== 2) begin errors++; $display("FAIL b2b_done got bad=%0d pulses=%0d want 0 2", done_err, dones); end
    checks++; if (q_err !== 0) begin errors++; $display("FAIL b2b_q got %0d bad results want 0", q_err); end
    checks++; if (adq_second !== 16'h0020) begin errors++; $display("FAIL b2b_adq got %h want 0020", adq_second); end
  endtask

  task automatic test_reset_mid();
    int lat, nrd, gaps, stray; logic [63:0] qv; logic kpd, aok;
    stray = 0;
    start = 1'b1; size = 2'b11; sgn = 1'b0; add = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (rd !== 1'b0 || kp !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctl got rd=%0b kp=%0b done=%0b want 0 0 0", rd, kp, done); end
    checks++; if (q !== 64'd0 || adq !== 16'd0) begin errors++; $display("FAIL midrst_data got q=%h adq=%h want 0 0", q, adq); end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || rd || kp) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray got %0d active cycles want 0", stray); end
    mem[16'h0300] = 8'h7F;
    run_load(16'h0300, 2'b00, 1'b1, lat, qv, kpd, nrd, aok, gaps);
    checks++; if (qv !== 64'h7F || lat !== 2) begin errors++; $display("FAIL midrst_reload got q=%h lat=%0d want 7f 2", qv, lat); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    ramq = 8'h00;
    test_reset();
    mem[16'h0010] = 8'h80;
    test_directed("byte_sign", 16'h0010, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'(i + 1);
    test_directed("dword", 16'h0100, 2'b11, 1'b1, 64'h0807_0605_0403_0201);
    mem[16'hFFFF] = 8'hFE; mem[16'h0000] = 8'hCA;
    test_directed("half_wrap", 16'hFFFF, 2'b01, 1'b0, 64'h0000_0000_0000_CAFE);
    mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'hDE; mem[16'h0042] = 8'hBC; mem[16'h0043] = 8'h9A;
    test_directed("word_sign", 16'h0040, 2'b10, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0);
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
